// File: rtl/onchip_delay_tap_mem_pkg.sv
// Shared types and constants for the on-chip multi-tap delay memory.
package onchip_delay_tap_mem_pkg;

  // Sequencer states: wait for a sample, issue tap reads, present the result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Control/status register layout.
  localparam int CTRL_CLEAR_BIT = 0;
  localparam int STAT_FILL_LSB  = 1;
  localparam int STAT_FILL_MSB  = 19;
  localparam int STAT_FILL_W    = STAT_FILL_MSB - STAT_FILL_LSB + 1;
  localparam int STAT_BUSY_BIT  = 31;

  // Legal parameter ranges.
  localparam int DEPTH_MIN  = 16;
  localparam int DEPTH_MAX  = 262144;
  localparam int N_TAPS_MIN = 1;
  localparam int N_TAPS_MAX = 8;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/delay_ram_sdp.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// The array carries no reset so it maps onto block RAM.
module delay_ram_sdp #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read port with one cycle of latency.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/onchip_delay_tap_mem.sv
// Multi-tap delay line: each accepted sample is written into a circular
// buffer, then N_TAPS delayed samples are read back one per cycle and
// presented together on a valid/ready output.
module onchip_delay_tap_mem
  import onchip_delay_tap_mem_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 65536,
  parameter int N_TAPS = 4,
  localparam int ADDR_W = clog2(DEPTH),
  localparam int TAP_W  = clog2(N_TAPS + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [N_TAPS*DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic [TAP_W-1:0]         cfg_address,
  input  logic                     cfg_write,
  input  logic                     cfg_read,
  input  logic [31:0]              cfg_writedata,
  output logic [31:0]              cfg_readdata
);

  generate
    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("onchip_delay_tap_mem: DEPTH must be a power of two in range");
    end
    if (N_TAPS < N_TAPS_MIN || N_TAPS > N_TAPS_MAX) begin : g_bad_taps
      $error("onchip_delay_tap_mem: N_TAPS out of range");
    end
  endgenerate

  localparam logic [ADDR_W:0]  FILL_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [TAP_W-1:0] CTRL_ADDR = TAP_W'(N_TAPS);

  state_e                    state_q, state_d;
  logic [TAP_W-1:0]          tap_cnt_q, tap_cnt_d;
  logic [ADDR_W-1:0]         base_q, base_d;
  logic [ADDR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]           fill_q, fill_d;
  logic [ADDR_W-1:0]         delay_q [N_TAPS];
  logic [ADDR_W-1:0]         delay_d [N_TAPS];
  logic [ADDR_W-1:0]         shadow_q [N_TAPS];
  logic [ADDR_W-1:0]         shadow_d [N_TAPS];
  logic                      tap_ok_q, tap_ok_d;
  logic [N_TAPS*DATA_W-1:0]  out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic                      clr_pend_q, clr_pend_d;
  logic [31:0]               cfg_readdata_q, cfg_readdata_d;

  logic                      ram_we;
  logic [ADDR_W-1:0]         ram_waddr;
  logic                      ram_re;
  logic [ADDR_W-1:0]         ram_raddr;
  logic [DATA_W-1:0]         ram_rdata;

  logic                      is_idle;
  logic                      accept;
  logic                      clr_req;
  logic                      clr_now;
  logic [31:0]               status_word;

  // Only the delay field and the clear bit of the write data are meaningful.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^cfg_writedata;

  assign is_idle   = (state_q == ST_IDLE);
  assign in_ready  = reset_n & is_idle;
  assign accept    = in_valid & in_ready;
  assign clr_req   = cfg_write & (cfg_address == CTRL_ADDR) & cfg_writedata[CTRL_CLEAR_BIT];
  // A clear only lands while idle; otherwise it waits in clr_pend_q.
  assign clr_now   = is_idle & (clr_pend_q | clr_req);

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign cfg_readdata = cfg_readdata_q;

  // Status word assembly from the current (pre-write) register values.
  always_comb begin
    status_word = '0;
    status_word[CTRL_CLEAR_BIT] = clr_pend_q;
    status_word[STAT_FILL_MSB:STAT_FILL_LSB] = STAT_FILL_W'(fill_q);
    status_word[STAT_BUSY_BIT] = ~is_idle;
  end

  // Next-state logic: register file, clear handling, sequencer and RAM ports.
  always_comb begin
    state_d        = state_q;
    tap_cnt_d      = tap_cnt_q;
    base_d         = base_q;
    wr_ptr_d       = wr_ptr_q;
    fill_d         = fill_q;
    delay_d        = delay_q;
    shadow_d       = shadow_q;
    tap_ok_d       = tap_ok_q;
    out_data_d     = out_data_q;
    out_valid_d    = out_valid_q;
    clr_pend_d     = clr_pend_q;
    cfg_readdata_d = cfg_readdata_q;
    ram_we         = 1'b0;
    ram_waddr      = wr_ptr_q;
    ram_re         = 1'b0;
    ram_raddr      = base_q;

    // Reads see the register values from before any same-cycle write.
    if (cfg_read) begin
      cfg_readdata_d = '0;
      for (int i = 0; i < N_TAPS; i++) begin
        if (cfg_address == TAP_W'(i)) begin
          cfg_readdata_d = 32'(delay_q[i]);
        end
      end
      if (cfg_address == CTRL_ADDR) begin
        cfg_readdata_d = status_word;
      end
    end

    for (int i = 0; i < N_TAPS; i++) begin
      if (cfg_write && cfg_address == TAP_W'(i)) begin
        delay_d[i] = cfg_writedata[ADDR_W-1:0];
      end
    end

    if (clr_now) begin
      wr_ptr_d   = '0;
      fill_d     = '0;
      clr_pend_d = 1'b0;
    end else if (clr_req) begin
      clr_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ram_we    = 1'b1;
          ram_waddr = clr_now ? '0 : wr_ptr_q;
          base_d    = ram_waddr;
          wr_ptr_d  = ram_waddr + ADDR_W'(1);
          if (clr_now) begin
            fill_d = (ADDR_W + 1)'(1);
          end else if (fill_q != FILL_MAX) begin
            fill_d = fill_q + (ADDR_W + 1)'(1);
          end
          shadow_d  = delay_q;
          tap_cnt_d = '0;
          state_d   = ST_READ;
        end
      end

      ST_READ: begin
        // Issue tap tap_cnt_q; data for the previous tap arrives this cycle.
        if (tap_cnt_q < CTRL_ADDR) begin
          ram_re = 1'b1;
        end
        for (int i = 0; i < N_TAPS; i++) begin
          if (tap_cnt_q == TAP_W'(i)) begin
            ram_raddr = base_q - shadow_q[i];
            tap_ok_d  = ({1'b0, shadow_q[i]} < fill_q);
          end
          if (tap_cnt_q == TAP_W'(i + 1)) begin
            out_data_d[i*DATA_W +: DATA_W] = tap_ok_q ? ram_rdata : '0;
          end
        end
        if (tap_cnt_q == CTRL_ADDR) begin
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          tap_cnt_d = tap_cnt_q + TAP_W'(1);
        end
      end

      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      tap_cnt_q      <= '0;
      base_q         <= '0;
      wr_ptr_q       <= '0;
      fill_q         <= '0;
      tap_ok_q       <= 1'b0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      clr_pend_q     <= 1'b0;
      cfg_readdata_q <= '0;
      for (int i = 0; i < N_TAPS; i++) begin
        delay_q[i]  <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      tap_cnt_q      <= tap_cnt_d;
      base_q         <= base_d;
      wr_ptr_q       <= wr_ptr_d;
      fill_q         <= fill_d;
      tap_ok_q       <= tap_ok_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      clr_pend_q     <= clr_pend_d;
      cfg_readdata_q <= cfg_readdata_d;
      delay_q        <= delay_d;
      shadow_q       <= shadow_d;
    end
  end

  delay_ram_sdp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (ram_we),
    .wr_addr(ram_waddr),
    .wr_data(in_data),
    .rd_en  (ram_re),
    .rd_addr(ram_raddr),
    .rd_data(ram_rdata)
  );

endmodule
